// File: rtl/acc_stream_ctrl.sv
// rtl/acc_stream_ctrl.sv - stream-to-register sequencer feeding the square accelerator
// Loads N_WORDS input words, kicks the engine, waits for idle, then streams the results out.
module acc_stream_ctrl #(
  parameter int N_WORDS = 16,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int RD_LAT  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          acc_wen,
  output logic          acc_start,
  output logic [AW-1:0] acc_addr,
  output logic [DW-1:0] acc_din,
  input  logic [DW-1:0] acc_dout,
  input  logic          acc_bsy,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(N_WORDS) + 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_WORDS - 1);
  localparam logic [LW-1:0] LAST_LAT = LW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_GAP,
    S_POLL,
    S_RDWAIT,
    S_OUT
  } state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] rcnt;
  logic [LW-1:0] lat_cnt;

  function automatic logic [AW-1:0] byte_addr(input logic [CW-1:0] idx);
    byte_addr = AW'(idx) << 2;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_LOAD;
      wcnt      <= '0;
      rcnt      <= '0;
      lat_cnt   <= '0;
      s_ready   <= 1'b1;
      m_valid   <= 1'b0;
      m_data    <= '0;
      acc_wen   <= 1'b0;
      acc_start <= 1'b0;
      acc_addr  <= '0;
      acc_din   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      acc_wen   <= 1'b0;
      acc_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_LOAD: begin
          if (s_valid && s_ready) begin
            acc_wen  <= 1'b1;
            acc_addr <= byte_addr(wcnt);
            acc_din  <= s_data;
            wcnt     <= wcnt + CW'(1);
            busy     <= 1'b1;
            if (wcnt == LAST_IDX) begin
              s_ready <= 1'b0;
              state   <= S_START;
            end
          end
        end
        // First START cycle lets the final write land; the second carries the pulse.
        S_START: begin
          if (!acc_start) acc_start <= 1'b1;
          else            state     <= S_GAP;
        end
        S_GAP: state <= S_POLL;
        S_POLL: begin
          if (!acc_bsy) begin
            rcnt     <= '0;
            lat_cnt  <= '0;
            acc_addr <= byte_addr('0);
            state    <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          if (lat_cnt == LAST_LAT) begin
            m_data  <= acc_dout;
            m_valid <= 1'b1;
            lat_cnt <= '0;
            state   <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (rcnt == LAST_IDX) begin
              done    <= 1'b1;
              wcnt    <= '0;
              rcnt    <= '0;
              s_ready <= 1'b1;
              busy    <= 1'b0;
              state   <= S_LOAD;
            end else begin
              rcnt     <= rcnt + CW'(1);
              acc_addr <= byte_addr(rcnt + CW'(1));
              state    <= S_RDWAIT;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_stream_ctrl.sv
// tb/tb_acc_stream_ctrl.sv - directed bench for acc_stream_ctrl with a table-driven squaring accelerator model
module tb_acc_stream_ctrl;

  localparam int N   = 16;
  localparam int RDL = 2;

  localparam logic [31:0] IN_TAB [16] = '{
    32'h3f000000, 32'h3e99999a, 32'h3f4ccccd, 32'h3fc00000,
    32'h40000000, 32'h40200000, 32'h40400000, 32'h40600000,
    32'h40800000, 32'h40900000, 32'h40a00000, 32'h40b00000,
    32'h40c00000, 32'h40d00000, 32'h40e00000, 32'h410c0000};
  localparam logic [31:0] OUT_TAB [16] = '{
    32'h3e800000, 32'h3db851ec, 32'h3f23d70a, 32'h40100000,
    32'h40800000, 32'h40c80000, 32'h41100000, 32'h41440000,
    32'h41800000, 32'h41a20000, 32'h41c80000, 32'h41f20000,
    32'h42100000, 32'h42290000, 32'h42440000, 32'h42992000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready = 1'b0;
  logic        acc_wen;
  logic        acc_start;
  logic [31:0] acc_addr;
  logic [31:0] acc_din;
  logic [31:0] acc_dout = '0;
  logic        acc_bsy;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  acc_stream_ctrl #(.N_WORDS(N), .DW(32), .AW(32), .RD_LAT(RDL)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .acc_wen(acc_wen), .acc_start(acc_start), .acc_addr(acc_addr),
    .acc_din(acc_din), .acc_dout(acc_dout), .acc_bsy(acc_bsy),
    .busy(busy), .done(done)
  );

  // Accelerator model: squares by table lookup, busy for bsy_len cycles after start.
  logic [31:0] mem [16];
  logic [31:0] res [16];
  int bsy_len = 0;
  int bsy_cnt = 0;
  int cyc = 0;
  assign acc_bsy = (bsy_cnt != 0);

  function automatic logic [31:0] sq(input logic [31:0] x);
    sq = ~x;
    for (int j = 0; j < 16; j++) if (IN_TAB[j] == x) sq = OUT_TAB[j];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (acc_wen) mem[acc_addr[5:2]] <= acc_din;
    if (acc_start) begin
      for (int i = 0; i < 16; i++) res[i] <= sq(mem[i]);
      bsy_cnt <= bsy_len;
    end else if (bsy_cnt != 0) begin
      bsy_cnt <= bsy_cnt - 1;
    end
    acc_dout <= res[acc_addr[5:2]];
  end

  // Event logs, sampled mid-cycle.
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc [$];
  int          hs_cyc [$];
  int          done_cyc [$];
  logic [31:0] out_q [$];
  int n_start, start_cyc, wr_at_start, both_hi, n_done, done_nrdy;
  int first_mv, bsy_seen, bsy_fall, bsy_n, bsy_viol, rdy_viol;
  int n_checks = 0;
  int n_pass = 0;

  always @(negedge clk) begin
    if (acc_wen) begin
      wr_addr.push_back(acc_addr);
      wr_data.push_back(acc_din);
      wr_cyc.push_back(cyc);
    end
    if (acc_start) begin
      n_start++;
      start_cyc = cyc;
      wr_at_start = wr_addr.size();
    end
    if (acc_wen && acc_start) both_hi++;
    if (s_valid && s_ready) hs_cyc.push_back(cyc);
    if (m_valid && m_ready) out_q.push_back(m_data);
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (done) begin
      n_done++;
      done_cyc.push_back(cyc);
      if (!s_ready) done_nrdy++;
    end
    if (acc_bsy) begin
      bsy_seen = 1;
      bsy_n++;
      if (acc_addr !== 32'h3c || m_valid) bsy_viol++;
    end else if (bsy_seen != 0 && bsy_fall < 0) begin
      bsy_fall = cyc;
    end
    if (s_ready && (m_valid || acc_bsy || acc_start)) rdy_viol++;
  end

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    hs_cyc.delete(); done_cyc.delete(); out_q.delete();
    n_start = 0; start_cyc = -1; wr_at_start = -1; both_hi = 0;
    n_done = 0; done_nrdy = 0; first_mv = -1; bsy_seen = 0;
    bsy_fall = -1; bsy_n = 0; bsy_viol = 0; rdy_viol = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_batch(input int rev, input int bubble, input int nw);
    for (int i = 0; i < nw; i++) begin
      int k;
      int guard;
      k = (rev != 0) ? N - 1 - i : i;
      guard = 0;
      s_valid = 1'b1;
      s_data = IN_TAB[k];
      while (!s_ready && guard < 3000) begin
        step();
        guard++;
      end
      if (guard >= 3000) begin
        n_checks++;
        $display("FAIL send_timeout word=%0d s_ready=%b required 1", i, s_ready);
        s_valid = 1'b0;
        return;
      end
      step();
      s_valid = 1'b0;
      if (bubble != 0) step();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (n_done < target && g < 5000) begin
      step();
      g++;
    end
    n_checks++;
    if (n_done < target) $display("FAIL done_timeout got=%0d required=%0d", n_done, target);
    else n_pass++;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) step();
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL rst_s_ready got=%b required=1", s_ready); else n_pass++;
    n_checks++;
    if ({m_valid, acc_wen, acc_start, done, busy} !== 5'b0)
      $display("FAIL rst_flags got=%b required=00000", {m_valid, acc_wen, acc_start, done, busy});
    else n_pass++;
    n_checks++;
    if ({m_data, acc_addr, acc_din} !== 96'h0)
      $display("FAIL rst_words got=%h/%h/%h required=0", m_data, acc_addr, acc_din);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_batch();
    int bad;
    clear_logs();
    bsy_len = 3;
    m_ready = 1'b1;
    send_batch(0, 0, 16);
    wait_done(1);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== IN_TAB[i]) bad++;
    n_checks++;
    if (wr_addr.size() != 16 || bad != 0)
      $display("FAIL full_writes count=%0d bad=%0d required 16/0", wr_addr.size(), bad);
    else n_pass++;
    n_checks++;
    if (wr_cyc[15] - wr_cyc[0] != 15) $display("FAIL full_throughput span=%0d required=15", wr_cyc[15] - wr_cyc[0]);
    else n_pass++;
    n_checks++;
    if (n_start != 1 || start_cyc != wr_cyc[15] + 1 || both_hi != 0)
      $display("FAIL full_start n=%0d cyc=%0d required 1 at %0d", n_start, start_cyc, wr_cyc[15] + 1);
    else n_pass++;
    n_checks++;
    if (first_mv != bsy_fall + RDL + 1)
      $display("FAIL full_first_result cyc=%0d required=%0d", first_mv, bsy_fall + RDL + 1);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) if (out_q[i] !== OUT_TAB[i]) bad++;
    n_checks++;
    if (out_q.size() != 16 || bad != 0)
      $display("FAIL full_outputs count=%0d bad=%0d required 16/0", out_q.size(), bad);
    else n_pass++;
    n_checks++;
    if (n_done != 1 || done_nrdy != 0 || busy !== 1'b0)
      $display("FAIL full_done n=%0d nrdy=%0d busy=%b required 1/0/0", n_done, done_nrdy, busy);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    int bad;
    clear_logs();
    bsy_len = 0;
    m_ready = 1'b1;
    send_batch(0, 1, 16);
    wait_done(1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_addr[i] !== 32'(4 * i)) bad++;
      if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != 2) bad++;
      if (i > 0 && hs_cyc[i] + 1 != wr_cyc[i]) bad++;
    end
    n_checks++;
    if (wr_addr.size() != 16 || bad != 0)
      $display("FAIL bubble_writes count=%0d bad=%0d required 16/0", wr_addr.size(), bad);
    else n_pass++;
    n_checks++;
    if (n_start != 1 || wr_at_start != 16)
      $display("FAIL bubble_start n=%0d writes_before=%0d required 1/16", n_start, wr_at_start);
    else n_pass++;
    n_checks++;
    if (first_mv != start_cyc + 5)
      $display("FAIL zero_busy_latency cyc=%0d required=%0d", first_mv, start_cyc + 5);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) if (out_q[i] !== OUT_TAB[i]) bad++;
    n_checks++;
    if (out_q.size() != 16 || bad != 0)
      $display("FAIL bubble_outputs count=%0d bad=%0d required 16/0", out_q.size(), bad);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad_d, bad_a, g;
    clear_logs();
    bsy_len = 2;
    m_ready = 1'b1;
    bad_d = 0;
    bad_a = 0;
    fork
      send_batch(0, 0, 16);
      begin
        g = 0;
        while (out_q.size() < 2 && g < 3000) begin step(); g++; end
        m_ready = 1'b0;
        g = 0;
        while (!m_valid && g < 100) begin step(); g++; end
        for (int i = 0; i < 5; i++) begin
          if (m_valid !== 1'b1 || m_data !== OUT_TAB[2]) bad_d++;
          if (acc_addr !== 32'h8) bad_a++;
          step();
        end
        m_ready = 1'b1;
      end
    join
    wait_done(1);
    n_checks++;
    if (bad_d != 0) $display("FAIL bp_hold_data bad=%0d data=%h required=%h", bad_d, m_data, OUT_TAB[2]);
    else n_pass++;
    n_checks++;
    if (bad_a != 0) $display("FAIL bp_hold_addr bad=%0d required 0", bad_a);
    else n_pass++;
    bad_d = 0;
    for (int i = 0; i < 16; i++) if (out_q[i] !== OUT_TAB[i]) bad_d++;
    n_checks++;
    if (out_q.size() != 16 || bad_d != 0)
      $display("FAIL bp_outputs count=%0d bad=%0d required 16/0", out_q.size(), bad_d);
    else n_pass++;
  endtask

  task automatic test_long_busy();
    int bad;
    clear_logs();
    bsy_len = 100;
    m_ready = 1'b1;
    send_batch(0, 0, 16);
    wait_done(1);
    n_checks++;
    if (bsy_n != 100 || bsy_viol != 0)
      $display("FAIL long_busy cycles=%0d viol=%0d required 100/0", bsy_n, bsy_viol);
    else n_pass++;
    n_checks++;
    if (first_mv != bsy_fall + RDL + 1)
      $display("FAIL long_first_result cyc=%0d required=%0d", first_mv, bsy_fall + RDL + 1);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) if (out_q[i] !== OUT_TAB[i]) bad++;
    n_checks++;
    if (out_q.size() != 16 || bad != 0)
      $display("FAIL long_outputs count=%0d bad=%0d required 16/0", out_q.size(), bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    clear_logs();
    bsy_len = 2;
    m_ready = 1'b1;
    send_batch(0, 0, 7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (s_ready !== 1'b1 || {acc_wen, busy, m_valid, done} !== 4'b0 || acc_addr !== 32'h0 || acc_din !== 32'h0)
      $display("FAIL midrst_outputs s_ready=%b flags=%b addr=%h din=%h required 1/0000/0/0",
               s_ready, {acc_wen, busy, m_valid, done}, acc_addr, acc_din);
    else n_pass++;
    repeat (10) step();
    n_checks++;
    if (n_done != 0 || n_start != 0)
      $display("FAIL midrst_no_done done=%0d start=%0d required 0/0", n_done, n_start);
    else n_pass++;
    clear_logs();
    send_batch(0, 0, 16);
    wait_done(1);
    bad = 0;
    for (int i = 0; i < 16; i++) if (wr_addr[i] !== 32'(4 * i) || out_q[i] !== OUT_TAB[i]) bad++;
    n_checks++;
    if (wr_addr.size() != 16 || out_q.size() != 16 || bad != 0)
      $display("FAIL midrst_rerun writes=%0d outs=%0d bad=%0d required 16/16/0", wr_addr.size(), out_q.size(), bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad;
    clear_logs();
    bsy_len = 2;
    m_ready = 1'b1;
    fork
      begin
        send_batch(0, 0, 16);
        send_batch(1, 0, 16);
      end
      wait_done(2);
    join
    n_checks++;
    if (hs_cyc.size() != 32 || done_cyc.size() < 1 || hs_cyc[16] != done_cyc[0])
      $display("FAIL b2b_accept_on_done hs=%0d first_b=%0d done=%0d", hs_cyc.size(), hs_cyc[16], done_cyc[0]);
    else n_pass++;
    n_checks++;
    if (rdy_viol != 0) $display("FAIL b2b_ready_while_draining viol=%0d required 0", rdy_viol);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_q[i] !== OUT_TAB[i]) bad++;
      if (out_q[16 + i] !== OUT_TAB[15 - i]) bad++;
    end
    n_checks++;
    if (out_q.size() != 32 || bad != 0 || n_start != 2 || n_done != 2)
      $display("FAIL b2b_outputs count=%0d bad=%0d starts=%0d dones=%0d required 32/0/2/2",
               out_q.size(), bad, n_start, n_done);
    else n_pass++;
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_full_batch();
    test_bubbles();
    test_backpressure();
    test_long_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_stream_ctrl.md
# acc_stream_ctrl

Stream-to-register sequencer that sits directly upstream of the square accelerator. It accepts a valid/ready stream of fp32 words and writes them into the accelerator's input buffer. It then pulses `start`, polls `bsy`, and reads the result buffer back out as a second valid/ready stream, so the host sees a plain streaming filter instead of a register-mapped engine.

## Interface
Parameters:
- `N_WORDS`, 16: words per batch, i.e. the accelerator buffer depth.
- `DW`, 32: data width.
- `AW`, 32: accelerator address width (byte address).
- `RD_LAT`, 2: cycles from `acc_addr` change to valid `acc_dout`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `s_valid`  in  1: input word valid.
- `s_data`  in  DW: input fp32 word.
- `s_ready`  out  1: input word accepted when `s_valid & s_ready`.
- `m_valid`  out  1: result word valid.
- `m_data`  out  DW: result fp32 word.
- `m_ready`  in  1: result consumed when `m_valid & m_ready`.
- `acc_wen`  out  1: accelerator write enable.
- `acc_start`  out  1: accelerator start pulse.
- `acc_addr`  out  AW: accelerator byte address (4·index).
- `acc_din`  out  DW: accelerator write data.
- `acc_dout`  in  DW: accelerator read data.
- `acc_bsy`  in  1: accelerator busy.
- `busy`  out  1: high in every state except IDLE/LOAD with zero words accepted.
- `done`  out  1: one-cycle pulse when the last result is consumed.

## Operation
States:
- **LOAD**: the reset state. `s_ready`=1. Each handshake registers `acc_wen`=1, `acc_addr`=4·wcnt and `acc_din`=`s_data` for the next cycle; wcnt increments. `acc_wen`=0 in any cycle without a handshake. When handshake N_WORDS is accepted, go to START.
- **START**: `acc_wen`=0, `s_ready`=0. `acc_start`=1 for exactly one cycle, then GAP.
- **GAP**: one idle cycle so the accelerator can raise `acc_bsy`. Then POLL.
- **POLL**: stay while `acc_bsy`=1. When `acc_bsy`=0, set rcnt=0 and go to RDWAIT.
- **RDWAIT**: drive `acc_addr`=4·rcnt and count RD_LAT cycles. On the last cycle, latch `acc_dout` into `m_data`, set `m_valid`=1, go to OUT.
- **OUT**: hold `m_data` and `m_valid` until `m_ready`. On handshake, clear `m_valid` and increment rcnt.
  - If rcnt was N_WORDS−1: pulse `done`, clear wcnt, go to LOAD.
  - Otherwise go to RDWAIT for the next address.

Rules:
- Counters wcnt and rcnt are each clog2(N_WORDS)+1 bits wide. Addresses never exceed 4·(N_WORDS−1).
- Data passes through unmodified. There is no fp arithmetic in this block.
- `s_valid` outside LOAD is ignored, since `s_ready`=0 there. `s_data` is never sampled without a handshake.
- `m_ready` asserted while `m_valid`=0 has no effect.
- `acc_wen` and `acc_start` are never high in the same cycle.
- A new batch is not accepted until every result of the previous batch has been consumed.

## Timing
- All outputs are registered. Reset values:
  - `s_ready`=1 (LOAD).
  - `m_valid`, `m_data`, `acc_wen`, `acc_start`, `acc_addr`, `acc_din`, `done` = 0.
  - `busy`=0.
- Input handshake in cycle t: the accelerator write is presented in cycle t+1. Sustained throughput is 1 word/cycle.
- Last word accepted at t: `acc_wen` at t+1, `acc_start` at t+2, GAP at t+3, first `acc_bsy` sample at t+4.
- `acc_bsy`=0 seen at p: `m_valid` rises at p+RD_LAT+1. With `m_ready` held high, there are RD_LAT+1 cycles per result word.
- `done` is asserted in the cycle after the final `m` handshake. LOAD `s_ready`=1 in that same cycle.
- `rst_n`=0 at any edge, including mid-write, mid-poll or while `m_valid` is held: all state and outputs return to reset values next cycle. The partial batch is discarded and no `done` is issued.
- `acc_bsy` already low at the GAP→POLL transition: advance immediately. A zero-length busy is legal.

## Test plan
- **Full batch, squaring bench model.** Stream 3f000000, 3e99999a, …, 410c0000 (0.5, 0.3, … 8.75) with `m_ready`=1. Required response:
  - 16 writes with `acc_addr` 0x00…0x3C.
  - One `acc_start`.
  - Outputs in order 3e800000, 3db851ec, …, 42992000.
  - `done` exactly once.
- **Input bubbles.** Toggle `s_valid` every other cycle → `acc_wen` follows with 1-cycle delay. Addresses stay contiguous with no gaps or duplicates. `acc_start` occurs only after word 16.
- **Output backpressure.** `m_ready`=0 for 5 cycles on word 3 → `m_data` (3f23d70a) and `m_valid` stay stable. No address advance until the handshake.
- **Long busy.** Model holds `acc_bsy` for 100 cycles → `acc_addr` stays static and `m_valid`=0 during busy. The first result appears RD_LAT+1 cycles after `acc_bsy` falls.
- **Reset mid-run.** `rst_n`=0 for one edge after 7 words loaded → all outputs at reset values. A following full batch produces correct results starting at address 0.
- **Back-to-back batches.** Second batch offered while the first drains → `s_ready`=0 until `done`. The second batch is accepted on the `done` cycle, and its results match.
